// File: rtl/booth_pkg.sv
// ============================================================================
// Module : booth_pkg
// Brief  : Shared state and Booth-op encodings for the sequential multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10
  } op_t;

  // Radix-2 Booth recoding of the current multiplier bit pair {Qr[0], q_1}.
  function automatic op_t booth_op(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_seq_mul_ctrl_if.sv
// ============================================================================
// Module : booth_seq_mul_ctrl_if
// Brief  : Start/busy/done handshake and operand/result bus of the multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface booth_seq_mul_ctrl_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

`default_nettype wire

// File: rtl/booth_step.sv
// ============================================================================
// Module : booth_step
// Brief  : One combinational radix-2 Booth step: add/sub then arithmetic shift.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] qr_i,
  input  logic             q1_i,
  input  logic [WIDTH:0]   mr_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] qr_o,
  output logic             q1_o
);

  op_t            op;
  logic [WIDTH:0] sum;

  always_comb begin
    op  = booth_op(qr_i[0], q1_i);
    sum = a_i;
    case (op)
      OP_ADD:  sum = a_i + mr_i;
      OP_SUB:  sum = a_i - mr_i;
      default: sum = a_i;
    endcase
    // Arithmetic right shift of {A, Qr, q_1}; A's MSB is replicated.
    {a_o, qr_o, q1_o} = {sum[WIDTH], sum, qr_i};
  end

endmodule

`default_nettype wire

// File: rtl/booth_seq_mul_ctrl.sv
// ============================================================================
// Module : booth_seq_mul_ctrl
// Brief  : Sequential radix-2 Booth multiplier, one step per clock.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_seq_mul_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  booth_seq_mul_ctrl_if.slave  bus
);

  state_t             state_q;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH-1:0]   qr_q, qr_d;
  logic               q1_q, q1_d;
  logic [WIDTH:0]     mr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] product_q;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a_i  (a_q),
    .qr_i (qr_q),
    .q1_i (q1_q),
    .mr_i (mr_q),
    .a_o  (a_d),
    .qr_o (qr_d),
    .q1_o (q1_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      qr_q      <= '0;
      q1_q      <= 1'b0;
      mr_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          // DONE accepts a start just like IDLE so results can run back-to-back.
          if (bus.start) begin
            a_q     <= '0;
            qr_q    <= bus.multiplier;
            q1_q    <= 1'b0;
            mr_q    <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_d;
          qr_q  <= qr_d;
          q1_q  <= q1_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            product_q <= {a_d[WIDTH-1:0], qr_d};
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_mul_ctrl.sv
// ============================================================================
// Module : tb_booth_seq_mul_ctrl
// Brief  : Directed vector table plus multi-cycle sequences for the multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_booth_seq_mul_ctrl;

  localparam int WIDTH = 4;

  typedef struct {
    logic [3:0] m;
    logic [3:0] q;
    logic [7:0] exp;
    string      name;
  } vec_t;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  booth_seq_mul_ctrl_if #(.WIDTH(WIDTH)) bus ();

  booth_seq_mul_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    else
      pass_cnt++;
  endtask

  // Entered at #1 after the accepting edge; leaves at #1 after the DONE->IDLE edge.
  task automatic wait_result(input logic [7:0] exp, input string nm, input bit full);
    int lat;
    bit busy_ok;
    lat     = 0;
    busy_ok = 1'b1;
    while (!bus.done && lat < 20) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (full) begin
      chk({nm, " latency"}, lat, WIDTH);
      chk({nm, " busy_during_run"}, busy_ok, 1);
      chk({nm, " busy_at_done"}, bus.busy, 0);
    end
    chk({nm, " product"}, bus.product, exp);
    @(posedge clk); #1;
    if (full) begin
      chk({nm, " done_one_cycle"}, bus.done, 0);
      chk({nm, " product_held"}, bus.product, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp,
                        input string nm, input bit full);
    bus.multiplicand = m;
    bus.multiplier   = q;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.start        = 1'b0;
    bus.multiplicand = ~m;
    bus.multiplier   = ~q;
    wait_result(exp, nm, full);
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] m4, q4;
    logic [7:0] e8;
    logic [3:0] pm[3];
    logic [3:0] pq[3];
    logic [7:0] pe[3];
    int         cyc;
    int         guard;
    bit         done_seen;

    pass_cnt  = 0;
    total_cnt = 0;

    vecs[0] = '{4'b1110, 4'b0101, 8'hF6, "m2_x_5"};
    vecs[1] = '{4'b0110, 4'b0111, 8'h2A, "6_x_7"};
    vecs[2] = '{4'b1000, 4'b1000, 8'h40, "m8_x_m8"};
    vecs[3] = '{4'b1000, 4'b0111, 8'hC8, "m8_x_7"};
    vecs[4] = '{4'b0000, 4'b1111, 8'h00, "0_x_m1"};
    vecs[5] = '{4'b0111, 4'b0111, 8'h31, "7_x_7"};
    vecs[6] = '{4'b1111, 4'b1111, 8'h01, "m1_x_m1"};
    vecs[7] = '{4'b0001, 4'b1000, 8'hF8, "1_x_m8"};

    // Reset held with start asserted.
    rst_n            = 1'b0;
    bus.start        = 1'b1;
    bus.multiplicand = 4'b1110;
    bus.multiplier   = 4'b0101;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset product", bus.product, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("accept_after_reset busy", bus.busy, 1);
    bus.start        = 1'b0;
    bus.multiplicand = 4'b0000;
    bus.multiplier   = 4'b0000;
    wait_result(8'hF6, "first_op", 1'b1);

    foreach (vecs[i])
      run_op(vecs[i].m, vecs[i].q, vecs[i].exp, vecs[i].name, 1'b1);

    // Start pulsed with new operands during RUN must not disturb the result.
    bus.multiplicand = 4'b0101;
    bus.multiplier   = 4'b1101;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start        = 1'b1;
    bus.multiplicand = 4'b0111;
    bus.multiplier   = 4'b0111;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_result(8'hF1, "start_pulse_in_run", 1'b0);

    // Back-to-back with start held high: results every WIDTH+1 cycles.
    pm[0] = 4'b0011; pq[0] = 4'b0010; pe[0] = 8'h06;
    pm[1] = 4'b1101; pq[1] = 4'b0100; pe[1] = 8'hF4;
    pm[2] = 4'b1001; pq[2] = 4'b1001; pe[2] = 8'h31;
    bus.multiplicand = pm[0];
    bus.multiplier   = pq[0];
    bus.start        = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin
        bus.multiplicand = pm[k+1];
        bus.multiplier   = pq[k+1];
      end else begin
        bus.start = 1'b0;
      end
      guard = 0;
      while (!bus.done && guard < 20) begin
        @(posedge clk); #1;
        cyc++;
        guard++;
      end
      chk($sformatf("b2b%0d product", k), bus.product, pe[k]);
      chk($sformatf("b2b%0d cycle", k), cyc, WIDTH + k * (WIDTH + 1));
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b idle busy", bus.busy, 0);

    // Asynchronous reset after step 2 aborts the operation.
    bus.multiplicand = 4'b0010;
    bus.multiplier   = 4'b0011;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset busy", bus.busy, 0);
    chk("midreset product", bus.product, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.done) done_seen = 1'b1;
    end
    chk("midreset no_done", done_seen, 0);
    run_op(4'b0011, 4'b1101, 8'hF7, "after_midreset", 1'b1);

    // Exhaustive sweep against a signed reference model.
    for (int mi = -8; mi < 8; mi++) begin
      for (int qi = -8; qi < 8; qi++) begin
        m4 = 4'(mi);
        q4 = 4'(qi);
        e8 = 8'(mi * qi);
        run_op(m4, q4, e8, $sformatf("sweep_%0d_x_%0d", mi, qi), 1'b0);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
